count_up_16_bit_timer_ctrl: RTL and testbench
=============================================

# count_up_16_bit_timer_ctrl

Sequencing controller for the 16-bit range-checked up-counter. Accepts start/stop/clear commands, latches a terminal value and run mode, and steps the counter in periodic or one-shot mode. Produces a single-cycle `tick` on each terminal event plus `busy`/`done` status. It is the timing source for blocks that need a 60000-count (0xEA60) period or a software-chosen one.

## Interface
- `RESET_LIMIT`, 16'hEA60, value of the latched terminal count after reset
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  start from IDLE/DONE, resume from PAUSE
- `stop`  in  1  pause a running count
- `clear`  in  1  abort to IDLE, count to 0
- `one_shot`  in  1  mode, sampled when starting from IDLE/DONE
- `limit`  in  16  terminal count, sampled when starting from IDLE/DONE
- `count_out`  out  16  current count
- `tick`  out  1  one-cycle registered pulse on terminal event
- `busy`  out  1  high in RUN or PAUSE
- `done`  out  1  high in DONE
- `state`  out  2  IDLE=0, RUN=1, PAUSE=2, DONE=3

## Operation
- Reset values: state IDLE, count_out 0, limit_q RESET_LIMIT, mode_q periodic, tick 0, busy 0, done 0.
- Command priority is `clear` > `stop` > `start`. Only the highest-priority asserted command acts.
- **IDLE**:
  - start: latch limit→limit_q and one_shot→mode_q; count_out←0; go to RUN.
  - stop: ignored.
- **RUN**: count_out advances by 1 each advance cycle.
  - Terminal event: count_out==limit_q on an advance cycle.
  - Periodic terminal: count_out←0, tick←1, stay in RUN.
  - One-shot terminal: count_out holds limit_q, tick←1, go to DONE.
  - stop: go to PAUSE; count_out holds; no advance that cycle.
  - start: ignored; no restart.
- **PAUSE**:
  - count_out, limit_q, mode_q and prescale state all hold.
  - start: go to RUN; counting continues from the held value.
- **DONE**:
  - count_out holds limit_q; done=1.
  - start: relatch the configuration and go to RUN from 0.
- clear in any state: IDLE, count_out←0, tick←0. limit_q and mode_q keep their values.
- Arithmetic:
  - Counting is unsigned 16-bit; the period is limit_q+1 advance cycles.
  - limit_q=0: periodic mode ticks on every advance cycle with count_out staying 0; one-shot goes to DONE on the first advance.
  - limit_q=16'hFFFF is legal. Because the terminal compare precedes the increment, count_out never overflows.
- `limit` and `one_shot` changes during RUN/PAUSE have no effect.

## Timing
- `start` high at edge N (from IDLE): state=RUN and count_out=0 after N. First advance at edge N+1 gives count_out=1.
- Periodic: count_out reads 0 for exactly one cycle per period. `tick` is high in that same cycle.
- One-shot: `tick` and `done` first go high in the same cycle.
- `stop` at edge M: count_out after M equals the value before M.
- `start` from PAUSE at edge P: the first advance occurs at edge P+1.
- `rst` overrides all inputs at any edge, mid-count included.
- All outputs are registered. There is no combinational input→output path.

## Configuration
- `PRESCALE_EN` defined:
  - Adds input `prescale` (8 bits), sampled with `limit`.
  - An advance cycle occurs once every prescale_q+1 clocks. prescale_q=0 is identical to no prescale.
  - The prescaler counter resets to 0 on start-from-IDLE/DONE, clear and rst. It holds in PAUSE.
  - `tick` stays one clk cycle wide.
- `PRESCALE_EN` not defined:
  - No `prescale` port.
  - Every RUN cycle without `stop` is an advance cycle.

## Structure
- Shared package `timer_ctrl_pkg`:
  - 2-bit state enum (IDLE/RUN/PAUSE/DONE).
  - Constants COUNT_W=16 and DEFAULT_LIMIT=16'hEA60.
- Sub-module `count_core_16`: a 16-bit counter with clear, hold, advance and terminal-compare inputs, and a wrap/terminal output. The controller FSM instantiates it.

## Test plan
- rst; start with limit=3, periodic → count_out 0,1,2,3,0,1…; tick high in each cycle where count_out returns to 0.
- limit=16'hEA60, periodic → first tick 60001 cycles after start; count_out never exceeds 0xEA60.
- limit=5, one_shot=1 → count reaches 5, then tick and done together; count_out holds 5; busy=0; a second start restarts from 0.
- stop at count 2, hold 10 cycles, then start → count_out stays 2, then continues 3,4…; start and stop asserted together in RUN → PAUSE.
- clear mid-run and rst mid-run (count 7) → next cycle IDLE, count_out 0, tick 0; clear+stop+start together → IDLE.
- `PRESCALE_EN`, prescale=2, limit=1 → count advances every 3 clocks; tick every 6 clocks, one cycle wide.

Source files
------------

// File: rtl/count_up_16_bit_timer_ctrl_pkg.sv
// ============================================================================
// timer_ctrl_pkg: shared state encoding and width constants for the timer.
// Revision: 1.0
// ============================================================================
`default_nettype none

package timer_ctrl_pkg;
  localparam int COUNT_W = 16;
  localparam logic [COUNT_W-1:0] DEFAULT_LIMIT = 16'hEA60;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;
endpackage

`default_nettype wire

// File: rtl/count_up_16_bit_timer_ctrl_if.sv
// ============================================================================
// count_up_16_bit_timer_ctrl_if: command/status bundle of the timer (PRESCALE_EN adds prescale).
// Revision: 1.0
// ============================================================================
`default_nettype none

interface count_up_16_bit_timer_ctrl_if;
  import timer_ctrl_pkg::*;

  logic               start;
  logic               stop;
  logic               clear;
  logic               one_shot;
  logic [COUNT_W-1:0] limit;
`ifdef PRESCALE_EN
  logic [7:0]         prescale;
`endif
  logic [COUNT_W-1:0] count_out;
  logic               tick;
  logic               busy;
  logic               done;
  logic [1:0]         state;

  modport master (
`ifdef PRESCALE_EN
    output prescale,
`endif
    output start, stop, clear, one_shot, limit,
    input  count_out, tick, busy, done, state
  );

  modport slave (
`ifdef PRESCALE_EN
    input  prescale,
`endif
    input  start, stop, clear, one_shot, limit,
    output count_out, tick, busy, done, state
  );
endinterface

`default_nettype wire

// File: rtl/count_up_16_bit_timer_ctrl_core.sv
// ============================================================================
// count_core_16: 16-bit up-counter with clear/hold/advance and terminal compare.
// Revision: 1.0
// ============================================================================
`default_nettype none

module count_core_16
  import timer_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               hold,
  input  logic               advance,
  input  logic               wrap_en,
  input  logic [COUNT_W-1:0] term,
  output logic [COUNT_W-1:0] count,
  output logic               terminal
);
  logic step;

  assign step     = advance && !hold;
  // Compare happens before the increment, so term=16'hFFFF never overflows.
  assign terminal = step && (count == term);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (step) begin
      if (count == term) begin
        if (wrap_en) count <= '0;
      end else begin
        count <= count + 1'b1;
      end
    end
  end
endmodule

`default_nettype wire

// File: rtl/count_up_16_bit_timer_ctrl.sv
// ============================================================================
// count_up_16_bit_timer_ctrl: start/stop/clear sequencer around count_core_16.
// Optional macro PRESCALE_EN adds an 8-bit advance prescaler. Revision: 1.0
// ============================================================================
`default_nettype none

module count_up_16_bit_timer_ctrl
  import timer_ctrl_pkg::*;
#(
  parameter logic [COUNT_W-1:0] RESET_LIMIT = DEFAULT_LIMIT
) (
  input  logic                          clk,
  input  logic                          rst,
  count_up_16_bit_timer_ctrl_if.slave   bus
);
  state_t             state_q, state_d;
  logic [COUNT_W-1:0] limit_q;
  logic               mode_q;
  logic               tick_q;
  logic               cmd_clear, cmd_stop, cmd_start;
  logic               load, advance, terminal, pre_hit;
  logic [COUNT_W-1:0] count;

  assign cmd_clear = bus.clear;
  assign cmd_stop  = bus.stop && !bus.clear;
  assign cmd_start = bus.start && !bus.stop && !bus.clear;
  assign load      = cmd_start && (state_q == IDLE || state_q == DONE);
  assign advance   = (state_q == RUN) && !cmd_clear && !cmd_stop && pre_hit;

`ifdef PRESCALE_EN
  logic [7:0] prescale_q, pcnt_q;

  assign pre_hit = (pcnt_q == prescale_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      prescale_q <= '0;
      pcnt_q     <= '0;
    end else begin
      if (load) prescale_q <= bus.prescale;
      if (load || cmd_clear) pcnt_q <= '0;
      else if (state_q == RUN && !cmd_stop) pcnt_q <= pre_hit ? 8'd0 : pcnt_q + 8'd1;
    end
  end
`else
  assign pre_hit = 1'b1;
`endif

  count_core_16 u_core (
    .clk      (clk),
    .rst      (rst),
    .clear    (cmd_clear || load),
    .hold     (state_q != RUN),
    .advance  (advance),
    .wrap_en  (!mode_q),
    .term     (limit_q),
    .count    (count),
    .terminal (terminal)
  );

  always_comb begin
    state_d = state_q;
    if (cmd_clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, DONE: if (cmd_start) state_d = RUN;
        RUN: begin
          if (cmd_stop) state_d = PAUSE;
          else if (terminal && mode_q) state_d = DONE;
        end
        PAUSE: if (cmd_start) state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      limit_q <= RESET_LIMIT;
      mode_q  <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= terminal;
      if (load) begin
        limit_q <= bus.limit;
        mode_q  <= bus.one_shot;
      end
    end
  end

  assign bus.count_out = count;
  assign bus.tick      = tick_q;
  assign bus.busy      = (state_q == RUN) || (state_q == PAUSE);
  assign bus.done      = (state_q == DONE);
  assign bus.state     = state_q;
endmodule

`default_nettype wire

// File: tb/tb_count_up_16_bit_timer_ctrl.sv
// ============================================================================
// tb_count_up_16_bit_timer_ctrl: directed self-checking bench for the timer.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_count_up_16_bit_timer_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  count_up_16_bit_timer_ctrl_if bus ();

  count_up_16_bit_timer_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic [15:0] lim, input logic os);
    bus.limit = lim; bus.one_shot = os; bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
  endtask

  task automatic do_clear();
    bus.clear = 1'b1; cyc(); bus.clear = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; cyc(); cyc(); rst = 1'b0;
    n_cmp++;
    if ({bus.state, bus.count_out, bus.tick, bus.busy, bus.done} !== {2'd0, 16'd0, 3'b000}) begin
      n_err++;
      $display("FAIL reset: got st=%0d cnt=%0d tk=%b bsy=%b dn=%b required 0/0/0/0/0",
               bus.state, bus.count_out, bus.tick, bus.busy, bus.done);
    end
  endtask

  task automatic test_periodic();
    go(16'd3, 1'b0);
    n_cmp++;
    if ({bus.state, bus.count_out, bus.tick, bus.busy} !== {2'd1, 16'd0, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL periodic_start: got st=%0d cnt=%0d tk=%b required 1/0/0", bus.state, bus.count_out, bus.tick);
    end
    for (int i = 1; i <= 9; i++) begin
      cyc();
      n_cmp++;
      if ({bus.count_out, bus.tick} !== {16'(i % 4), (i % 4) == 0}) begin
        n_err++;
        $display("FAIL periodic_%0d: got cnt=%0d tk=%b required cnt=%0d tk=%b",
                 i, bus.count_out, bus.tick, i % 4, (i % 4) == 0);
      end
    end
    do_clear();
    go(16'd0, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      cyc();
      n_cmp++;
      if ({bus.count_out, bus.tick} !== {16'd0, 1'b1}) begin
        n_err++;
        $display("FAIL limit0_%0d: got cnt=%0d tk=%b required cnt=0 tk=1", i, bus.count_out, bus.tick);
      end
    end
    do_clear();
  endtask

  task automatic test_long_period();
    int  k = 0;
    int  first = -1;
    bit  over = 1'b0;
    go(16'hEA60, 1'b0);
    while (first < 0 && k < 70000) begin
      cyc();
      k++;
      if (bus.count_out > 16'hEA60) over = 1'b1;
      if (bus.tick) first = k;
    end
    n_cmp++;
    if (first != 60001) begin
      n_err++;
      $display("FAIL eA60_first_tick: got cycle %0d required 60001", first);
    end
    n_cmp++;
    if (over !== 1'b0) begin
      n_err++;
      $display("FAIL eA60_range: got overrange=%b required 0", over);
    end
    do_clear();
  endtask

  task automatic test_one_shot();
    go(16'd5, 1'b1);
    for (int i = 1; i <= 5; i++) begin
      cyc();
      n_cmp++;
      if ({bus.count_out, bus.tick, bus.done} !== {16'(i), 2'b00}) begin
        n_err++;
        $display("FAIL oneshot_cnt_%0d: got cnt=%0d tk=%b dn=%b required cnt=%0d 0 0",
                 i, bus.count_out, bus.tick, bus.done, i);
      end
    end
    cyc();
    n_cmp++;
    if ({bus.state, bus.count_out, bus.tick, bus.done, bus.busy} !== {2'd3, 16'd5, 3'b110}) begin
      n_err++;
      $display("FAIL oneshot_term: got st=%0d cnt=%0d tk=%b dn=%b bsy=%b required 3/5/1/1/0",
               bus.state, bus.count_out, bus.tick, bus.done, bus.busy);
    end
    cyc(); cyc();
    n_cmp++;
    if ({bus.state, bus.count_out, bus.tick, bus.done} !== {2'd3, 16'd5, 2'b01}) begin
      n_err++;
      $display("FAIL oneshot_hold: got st=%0d cnt=%0d tk=%b dn=%b required 3/5/0/1",
               bus.state, bus.count_out, bus.tick, bus.done);
    end
    go(16'd5, 1'b1);
    n_cmp++;
    if ({bus.state, bus.count_out, bus.done} !== {2'd1, 16'd0, 1'b0}) begin
      n_err++;
      $display("FAIL oneshot_restart: got st=%0d cnt=%0d dn=%b required 1/0/0", bus.state, bus.count_out, bus.done);
    end
    cyc();
    n_cmp++;
    if (bus.count_out !== 16'd1) begin
      n_err++;
      $display("FAIL oneshot_restart_adv: got cnt=%0d required 1", bus.count_out);
    end
    do_clear();
  endtask

  task automatic test_pause();
    bit held = 1'b1;
    go(16'd9, 1'b0);
    cyc(); cyc();
    bus.stop = 1'b1; cyc(); bus.stop = 1'b0;
    n_cmp++;
    if ({bus.state, bus.count_out, bus.busy} !== {2'd2, 16'd2, 1'b1}) begin
      n_err++;
      $display("FAIL pause_enter: got st=%0d cnt=%0d bsy=%b required 2/2/1", bus.state, bus.count_out, bus.busy);
    end
    for (int i = 0; i < 10; i++) begin
      bus.limit = 16'd1; bus.one_shot = 1'b1;
      cyc();
      if (bus.count_out !== 16'd2 || bus.state !== 2'd2) held = 1'b0;
    end
    n_cmp++;
    if (held !== 1'b1) begin
      n_err++;
      $display("FAIL pause_hold: got held=%b required 1", held);
    end
    bus.start = 1'b1; cyc(); bus.start = 1'b0;
    n_cmp++;
    if ({bus.state, bus.count_out} !== {2'd1, 16'd2}) begin
      n_err++;
      $display("FAIL pause_resume: got st=%0d cnt=%0d required 1/2", bus.state, bus.count_out);
    end
    cyc(); cyc();
    n_cmp++;
    if (bus.count_out !== 16'd4) begin
      n_err++;
      $display("FAIL pause_continue: got cnt=%0d required 4", bus.count_out);
    end
    bus.start = 1'b1; bus.stop = 1'b1; cyc(); bus.start = 1'b0; bus.stop = 1'b0;
    n_cmp++;
    if ({bus.state, bus.count_out} !== {2'd2, 16'd4}) begin
      n_err++;
      $display("FAIL start_stop_run: got st=%0d cnt=%0d required 2/4", bus.state, bus.count_out);
    end
    do_clear();
  endtask

  task automatic test_clear_rst();
    go(16'd7, 1'b0);
    repeat (7) cyc();
    do_clear();
    n_cmp++;
    if ({bus.state, bus.count_out, bus.tick} !== {2'd0, 16'd0, 1'b0}) begin
      n_err++;
      $display("FAIL clear_at_term: got st=%0d cnt=%0d tk=%b required 0/0/0", bus.state, bus.count_out, bus.tick);
    end
    go(16'd20, 1'b0);
    repeat (7) cyc();
    rst = 1'b1; cyc(); rst = 1'b0;
    n_cmp++;
    if ({bus.state, bus.count_out, bus.tick, bus.busy} !== {2'd0, 16'd0, 2'b00}) begin
      n_err++;
      $display("FAIL rst_midrun: got st=%0d cnt=%0d tk=%b bsy=%b required 0/0/0/0",
               bus.state, bus.count_out, bus.tick, bus.busy);
    end
    go(16'd20, 1'b0);
    repeat (3) cyc();
    bus.clear = 1'b1; bus.stop = 1'b1; bus.start = 1'b1;
    cyc();
    bus.clear = 1'b0; bus.stop = 1'b0; bus.start = 1'b0;
    n_cmp++;
    if ({bus.state, bus.count_out} !== {2'd0, 16'd0}) begin
      n_err++;
      $display("FAIL clear_all_cmds: got st=%0d cnt=%0d required 0/0", bus.state, bus.count_out);
    end
  endtask

`ifdef PRESCALE_EN
  task automatic test_prescale();
    bus.prescale = 8'd2;
    go(16'd1, 1'b0);
    bus.prescale = 8'd0;
    for (int k = 1; k <= 12; k++) begin
      cyc();
      n_cmp++;
      if ({bus.count_out, bus.tick} !== {16'((k / 3) % 2), (k % 6) == 0}) begin
        n_err++;
        $display("FAIL prescale_%0d: got cnt=%0d tk=%b required cnt=%0d tk=%b",
                 k, bus.count_out, bus.tick, (k / 3) % 2, (k % 6) == 0);
      end
    end
    do_clear();
  endtask
`endif

  initial begin
    bus.start = 1'b0; bus.stop = 1'b0; bus.clear = 1'b0;
    bus.one_shot = 1'b0; bus.limit = 16'd0;
`ifdef PRESCALE_EN
    bus.prescale = 8'd0;
`endif
    test_reset();
    test_periodic();
    test_one_shot();
    test_pause();
    test_clear_rst();
`ifdef PRESCALE_EN
    test_prescale();
`endif
    test_long_period();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

`default_nettype wire
